seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial pattern detector: generalises the fixed 4-bit "1101" Moore detector to a configurable pattern width, a runtime-loadable pattern, selectable overlapping/non-overlapping detection and an optional saturating match counter. Sits directly on a serial bit stream alongside the flex shift-register blocks and flags each occurrence of the programmed pattern. Output is Moore-style: `match` is registered and depends only on the accepted-bit history.

## Interface
- `PAT_W`, 4: pattern width in bits; legal range 2..32.
- `DEFAULT_PAT`, 4'b1101: pattern register value after reset; width `PAT_W`.
- `CNT_W`, 8: width of `match_count`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  reset; one clock, synchronous, active-low.
- `bit_valid`  in  1  `bit_in` is accepted on this edge.
- `bit_in`  in  1  serial data bit.
- `load`  in  1  load `pattern_in` into the pattern register.
- `pattern_in`  in  `PAT_W`  new pattern; MSB is the first bit of the sequence.
- `overlap_en`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `match`  out  1  last `PAT_W` accepted bits equal the pattern.
- `match_count`  out  `CNT_W`  number of detections since reset/load, saturating.

## Operation
- State:
  - history shift register `hist[PAT_W-1:0]`; each accepted bit enters at the LSB and shifts toward the MSB.
  - fill counter `fill`, `$clog2(PAT_W+1)` bits, saturating at `PAT_W`.
  - pattern register `pat`.
  - `match` register.
  - `match_count` register.
- Accepted bit, defined as `bit_valid`=1 and `load`=0:
  - `hist_n = {hist[PAT_W-2:0], bit_in}`.
  - `fill_n = min(fill+1, PAT_W)`.
  - `match` <= (`fill_n`==`PAT_W`) && (`hist_n`==`pat`).
- Detection event: an accepted bit that sets `match`.
  - Non-overlap mode (`overlap_en`=0): `fill` is cleared to 0 on the same edge, so the next detection needs `PAT_W` fresh bits.
  - Overlap mode: `fill` stays at `PAT_W`.
- `overlap_en` is sampled on each accepted bit; changing it mid-stream is legal.
- Edge with no accepted bit: `hist`, `fill` and `match` hold. `match` therefore stays high until the next accepted bit.
- `load`=1 on an edge:
  - `pat` <= `pattern_in`.
  - `hist`, `fill`, `match` and `match_count` are cleared.
  - `bit_valid` on the same edge is ignored; `load` wins.
- `match_count` increments by 1 on each detection event and holds at all-ones.

## Timing
- Reset values: `match`=0, `match_count`=0, `hist`=0, `fill`=0, `pat`=`DEFAULT_PAT`.
- `n_rst` low on an edge overrides `load` and `bit_valid`.
- Reset asserted mid-stream discards partial history. After release, `PAT_W` new accepted bits are required before `match` can assert.
- Latency: `match` is valid after the rising edge that accepts the final pattern bit. It is visible within propagation delay (at most 0.8 ns budget at the 2.5 ns clock).
- `match_count` updates on the same edge as `match`.
- No combinational path from any input to any output.

## Configuration
- `SEQ_DETECT_COUNT_EN` defined:
  - the `match_count` register and its saturating incrementer are built as described above.
- `SEQ_DETECT_COUNT_EN` not defined:
  - no counter logic is built.
  - the `match_count` port remains and is tied to 0.
  - all other behaviour is identical.

## Structure
- Package `seq_detect_pkg` holds:
  - `localparam` defaults: `SEQ_PAT_W_DEF`=4, `SEQ_DEFAULT_PAT`=4'b1101, `SEQ_CNT_W_DEF`=8.
  - typedef `seq_mode_t` enum {`SEQ_NON_OVERLAP`=0, `SEQ_OVERLAP`=1}, used for the `overlap_en` decode.
- One sub-module, `seq_history_sr`:
  - `PAT_W`-bit serial-in/parallel-out shift register plus the saturating fill counter.
  - Inputs: shift enable and clear (clear driven by `load` or by a non-overlap detection).
  - Outputs: `hist` and `full`.
- Top level holds `pat`, the compare, `match` and the counter.

## Test plan
- Reset: `n_rst`=0 for 2 cycles with `bit_valid`=1, `bit_in`=1 -> `match`=0 and `match_count`=0 throughout; after release `match` stays 0.
- Default pattern: stream 1,1,0,1 -> `match`=1 after the 4th edge and held while `bit_valid`=0. Then stream 0,1,0,1,1 -> `match`=0 at the end.
- Overlap: `overlap_en`=1, stream 1,1,0,1,1,0,1,1,0,1 -> `match` asserts after bits 4, 7 and 10; `match_count`=3.
- Non-overlap: `overlap_en`=0, stream 1,1,0,1,1,0,1 -> `match` asserts after bit 4 only; `match_count`=1.
- Load: `load`=1 with `pattern_in`=4'b0110 and `bit_valid`=1 on the same edge -> the bit is dropped and `match_count` cleared. Then stream 0,1,1,0 -> `match`=1. Then stream 1,1,0,1 -> `match`=0.
- Saturation, with `SEQ_DETECT_COUNT_EN` and `CNT_W`=2: 5 overlapping detections -> `match_count`=3. Without the macro -> `match_count`=0 and `match` identical.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared defaults and mode encoding for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam int         SEQ_PAT_W_DEF   = 4;
  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1101;
  localparam int         SEQ_CNT_W_DEF   = 8;

  typedef enum logic {
    SEQ_NON_OVERLAP = 1'b0,
    SEQ_OVERLAP     = 1'b1
  } seq_mode_t;

endpackage

// File: rtl/seq_history_sr.sv
// Serial-in history window with saturating fill counter for seq_detect_param.
// Outputs describe the window as it stands once the current bit_in is shifted in.
module seq_history_sr #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift,
  input  logic             clear,
  input  logic             bit_in,
  output logic [PAT_W-1:0] hist,
  output logic             full
);

  localparam int             FW       = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);

  // The oldest bit falls out on every shift, so only PAT_W-1 bits need storing.
  logic [PAT_W-2:0] hist_q;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;

  // Shifted window and saturating next fill value.
  always_comb begin
    hist = {hist_q, bit_in};
    if (fill == FILL_MAX) begin
      fill_next = FILL_MAX;
    end else begin
      fill_next = fill + FW'(1);
    end
    full = (fill_next == FILL_MAX);
  end

  // History and fill registers; clear wins over shift.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hist_q <= {(PAT_W-1){1'b0}};
      fill   <= {FW{1'b0}};
    end else if (clear) begin
      hist_q <= {(PAT_W-1){1'b0}};
      fill   <= {FW{1'b0}};
    end else if (shift) begin
      hist_q <= hist[PAT_W-2:0];
      fill   <= fill_next;
    end else begin
      hist_q <= hist_q;
      fill   <= fill;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector with loadable pattern and overlap control.
// Optional saturating match counter is built when SEQ_DETECT_COUNT_EN is defined.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W       = SEQ_PAT_W_DEF,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT),
  parameter int               CNT_W       = SEQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap_en,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] window;
  logic             window_full;
  logic             accept;
  logic             detect;
  logic             sr_clear;
  seq_mode_t        mode;

  // Accept/detect decode; a non-overlap hit restarts the window from scratch.
  always_comb begin
    mode     = seq_mode_t'(overlap_en);
    accept   = bit_valid & ~load;
    detect   = accept & window_full & (window == pat);
    sr_clear = load | (detect & (mode == SEQ_NON_OVERLAP));
  end

  seq_history_sr #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk    (clk),
    .n_rst  (n_rst),
    .shift  (accept),
    .clear  (sr_clear),
    .bit_in (bit_in),
    .hist   (window),
    .full   (window_full)
  );

  // Pattern and match registers; match holds between accepted bits.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pat   <= DEFAULT_PAT;
      match <= 1'b0;
    end else if (load) begin
      pat   <= pattern_in;
      match <= 1'b0;
    end else if (accept) begin
      pat   <= pat;
      match <= detect;
    end else begin
      pat   <= pat;
      match <= match;
    end
  end

`ifdef SEQ_DETECT_COUNT_EN
  // Saturating detection counter, cleared by reset and load.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      match_count <= {CNT_W{1'b0}};
    end else if (load) begin
      match_count <= {CNT_W{1'b0}};
    end else if (detect && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end else begin
      match_count <= match_count;
    end
  end
`else
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
